// File: rtl/tick_scheduler_if.sv
// Config request port of tick_scheduler: valid/ready handshake carrying
// target channel, divide value and run/stop enable.
interface tick_scheduler_if #(
  parameter int CH_W  = 2,
  parameter int DIV_W = 24
);
  logic             CFG_VALID;
  logic             CFG_READY;
  logic [CH_W-1:0]  CFG_CH;
  logic [DIV_W-1:0] CFG_DIV;
  logic             CFG_EN;

  modport master (output CFG_VALID, CFG_CH, CFG_DIV, CFG_EN, input CFG_READY);
  modport slave  (input CFG_VALID, CFG_CH, CFG_DIV, CFG_EN, output CFG_READY);
endinterface

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: per-channel divide counters with TICK strobe
// and SLOW toggle. Optional SYNC restart input enabled by defining SCHED_SYNC_EN.
module tick_scheduler #(
  parameter int               NUM_CH      = 4,
  parameter int               DIV_W       = 24,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 24'hFFFFFF
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
`ifdef SCHED_SYNC_EN
  input  logic              SYNC,
`endif
  tick_scheduler_if.slave   cfg,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] SLOW,
  output logic [NUM_CH-1:0] EN_STATUS
);
  localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0]   NUM_CH_C = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } ch_state_e;

  ch_state_e          state_r [NUM_CH];
  ch_state_e          state_s [NUM_CH];
  logic [DIV_W-1:0]   cnt_r   [NUM_CH];
  logic [DIV_W-1:0]   cnt_s   [NUM_CH];
  logic [DIV_W-1:0]   div_r   [NUM_CH];
  logic [DIV_W-1:0]   div_s   [NUM_CH];
  logic [NUM_CH-1:0]  tick_r, tick_s;
  logic [NUM_CH-1:0]  slow_r, slow_s;
  logic [NUM_CH-1:0]  en_r, en_s;
  logic [NUM_CH-1:0]  hit_s, wrap_s, apply_s, store_s;
  logic               pend_valid_r, pend_valid_s;
  logic [CH_W-1:0]    pend_ch_r, pend_ch_s;
  logic [DIV_W-1:0]   pend_div_r, pend_div_s;
  logic               pend_en_r, pend_en_s;
  logic               ready_r, ready_s;
  logic               accept_s, ch_ok_s, sync_s;

`ifdef SCHED_SYNC_EN
  assign sync_s = SYNC;
`else
  assign sync_s = 1'b0;
`endif

  assign cfg.CFG_READY = ready_r;
  assign TICK          = tick_r;
  assign SLOW          = slow_r;
  assign EN_STATUS     = en_r;

  // Next-state and output decode for every channel plus the shared pending slot
  always_comb begin
    accept_s     = cfg.CFG_VALID & ready_r;
    ch_ok_s      = ({1'b0, cfg.CFG_CH} < NUM_CH_C);
    pend_valid_s = pend_valid_r;
    pend_ch_s    = pend_ch_r;
    pend_div_s   = pend_div_r;
    pend_en_s    = pend_en_r;
    for (int i = 0; i < NUM_CH; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      div_s[i]   = div_r[i];
      tick_s[i]  = 1'b0;
      slow_s[i]  = slow_r[i];
      hit_s[i]   = accept_s & ch_ok_s & (cfg.CFG_CH == CH_W'(i));
      wrap_s[i]  = (cnt_r[i] == div_r[i]);
      apply_s[i] = pend_valid_r & (pend_ch_r == CH_W'(i)) & (state_r[i] == ST_PEND);
      store_s[i] = hit_s[i] & (state_r[i] == ST_RUN);
      case (state_r[i])
        ST_OFF: begin
          cnt_s[i] = '0;
          if (hit_s[i]) begin
            div_s[i]   = cfg.CFG_DIV;
            state_s[i] = cfg.CFG_EN ? ST_RUN : ST_OFF;
          end else begin
            state_s[i] = ST_OFF;
          end
        end
        ST_RUN, ST_PEND: begin
          if (sync_s | wrap_s[i]) begin
            // SYNC restarts the phase silently and wins over a same-edge wrap
            cnt_s[i]  = '0;
            tick_s[i] = ~sync_s;
            slow_s[i] = sync_s ? 1'b0 : ~slow_r[i];
            if (apply_s[i]) begin
              div_s[i]     = pend_div_r;
              pend_valid_s = 1'b0;
              if (pend_en_r) begin
                state_s[i] = ST_RUN;
              end else begin
                state_s[i] = ST_OFF;
                slow_s[i]  = 1'b0;
              end
            end else begin
              state_s[i] = ST_RUN;
            end
          end else begin
            cnt_s[i] = cnt_r[i] + DIV_W'(1);
          end
          state_s[i] = store_s[i] ? ST_PEND : state_s[i];
        end
        default: begin
          state_s[i] = ST_OFF;
          cnt_s[i]   = '0;
        end
      endcase
      en_s[i] = (state_s[i] != ST_OFF);
    end
    if (|store_s) begin
      pend_valid_s = 1'b1;
      pend_ch_s    = cfg.CFG_CH;
      pend_div_s   = cfg.CFG_DIV;
      pend_en_s    = cfg.CFG_EN;
    end else begin
      pend_ch_s    = pend_ch_r;
    end
    ready_s = ~pend_valid_s;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= ST_OFF;
        cnt_r[i]   <= '0;
        div_r[i]   <= DEFAULT_DIV;
      end
      tick_r       <= '0;
      slow_r       <= '0;
      en_r         <= '0;
      pend_valid_r <= 1'b0;
      pend_ch_r    <= '0;
      pend_div_r   <= '0;
      pend_en_r    <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
        div_r[i]   <= div_s[i];
      end
      tick_r       <= tick_s;
      slow_r       <= slow_s;
      en_r         <= en_s;
      pend_valid_r <= pend_valid_s;
      pend_ch_r    <= pend_ch_s;
      pend_div_r   <= pend_div_s;
      pend_en_r    <= pend_en_s;
      ready_r      <= ready_s;
    end
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: vector table for reset/start-up/basic ticking,
// hand sequences for deferred updates, stalls, stop, reset and SYNC (SCHED_SYNC_EN).
module tb_tick_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] tick, slow, ens;
  logic [2:0] tick3, slow3, ens3;
  int         errors = 0;
  int         checks = 0;

  tick_scheduler_if #(.CH_W(2), .DIV_W(24)) cfg_if ();
  tick_scheduler_if #(.CH_W(2), .DIV_W(8))  cfg3_if ();

  tick_scheduler #(.NUM_CH(4), .DIV_W(24), .DEFAULT_DIV(24'hFFFFFF)) u_dut (
    .CLOCK(clk), .RESET_N(rst_n),
`ifdef SCHED_SYNC_EN
    .SYNC(sync),
`endif
    .cfg(cfg_if), .TICK(tick), .SLOW(slow), .EN_STATUS(ens)
  );

  tick_scheduler #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(8'hFF)) u_dut3 (
    .CLOCK(clk), .RESET_N(rst_n),
`ifdef SCHED_SYNC_EN
    .SYNC(1'b0),
`endif
    .cfg(cfg3_if), .TICK(tick3), .SLOW(slow3), .EN_STATUS(ens3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [1:0]  ch;
    logic [23:0] div;
    logic        en;
    logic [3:0]  tick;
    logic [3:0]  slow;
    logic [3:0]  ens;
    logic        ready;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic req(input logic v, input logic [1:0] ch, input logic [23:0] d, input logic en);
    cfg_if.CFG_VALID = v;
    cfg_if.CFG_CH    = ch;
    cfg_if.CFG_DIV   = d;
    cfg_if.CFG_EN    = en;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    req(1'b0, 2'd0, 24'd0, 1'b0);
    cfg3_if.CFG_VALID = 1'b0;
    cfg3_if.CFG_CH    = 2'd0;
    cfg3_if.CFG_DIV   = 8'd0;
    cfg3_if.CFG_EN    = 1'b0;

    //           rst   vld   ch     div     en     tick     slow     ens      rdy
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 2'd0, 24'd3, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 2'd1, 24'd0, 1'b1, 4'b0000, 4'b0000, 4'b0011, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0010, 4'b0010, 4'b0011, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0010, 4'b0000, 4'b0011, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0011, 4'b0011, 4'b0011, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 2'd0, 24'd0, 1'b0, 4'b0010, 4'b0001, 4'b0011, 1'b1};

    #2;
    for (int v = 0; v < 16; v++) begin
      rst_n = vecs[v].rst_n;
      req(vecs[v].valid, vecs[v].ch, vecs[v].div, vecs[v].en);
      step();
      chk($sformatf("vec%0d tick", v),  {28'd0, tick}, {28'd0, vecs[v].tick});
      chk($sformatf("vec%0d slow", v),  {28'd0, slow}, {28'd0, vecs[v].slow});
      chk($sformatf("vec%0d ens", v),   {28'd0, ens},  {28'd0, vecs[v].ens});
      chk($sformatf("vec%0d ready", v), {31'd0, cfg_if.CFG_READY}, {31'd0, vecs[v].ready});
    end
    req(1'b0, 2'd0, 24'd0, 1'b0);

    // Deferred update: ch0 D=3 -> D=1, accepted on the edge right after a wrap
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      seen = tick[0];
    end
    chk("upd wait tick0", {31'd0, seen}, 32'd1);
    req(1'b1, 2'd0, 24'd1, 1'b1);
    step();
    req(1'b0, 2'd0, 24'd0, 1'b0);
    chk("upd s1 ready", {31'd0, cfg_if.CFG_READY}, 32'd0);
    chk("upd s1 tick0", {31'd0, tick[0]}, 32'd0);
    step();
    chk("upd s2 ready", {31'd0, cfg_if.CFG_READY}, 32'd0);
    step();
    chk("upd s3 ready", {31'd0, cfg_if.CFG_READY}, 32'd0);
    chk("upd s3 tick0", {31'd0, tick[0]}, 32'd0);
    step();
    chk("upd s4 tick0", {31'd0, tick[0]}, 32'd1);
    chk("upd s4 ready", {31'd0, cfg_if.CFG_READY}, 32'd1);
    step();
    chk("upd s5 tick0", {31'd0, tick[0]}, 32'd0);
    step();
    chk("upd s6 tick0", {31'd0, tick[0]}, 32'd1);
    step();
    chk("upd s7 tick0", {31'd0, tick[0]}, 32'd0);
    step();
    chk("upd s8 tick0", {31'd0, tick[0]}, 32'd1);

    // Stop ch0 (D=1): one final tick at the wrap, then SLOW forced low and idle
    req(1'b1, 2'd0, 24'd7, 1'b0);
    step();
    req(1'b0, 2'd0, 24'd0, 1'b0);
    chk("stop s1 ready", {31'd0, cfg_if.CFG_READY}, 32'd0);
    chk("stop s1 ens0", {31'd0, ens[0]}, 32'd1);
    step();
    chk("stop s2 tick0", {31'd0, tick[0]}, 32'd1);
    chk("stop s2 slow0", {31'd0, slow[0]}, 32'd0);
    chk("stop s2 ens", {28'd0, ens}, 32'h2);
    chk("stop s2 ready", {31'd0, cfg_if.CFG_READY}, 32'd1);
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("stop idle%0d tick0", n), {31'd0, tick[0]}, 32'd0);
      chk($sformatf("stop idle%0d slow0", n), {31'd0, slow[0]}, 32'd0);
    end

    // Stall: ch2 request held while ch0 update occupies the slot
    req(1'b1, 2'd0, 24'd3, 1'b1);
    step();
    chk("stall a ens", {28'd0, ens}, 32'h3);
    step();
    chk("stall b ready", {31'd0, cfg_if.CFG_READY}, 32'd0);
    req(1'b1, 2'd2, 24'd2, 1'b1);
    step();
    chk("stall c1 ready", {31'd0, cfg_if.CFG_READY}, 32'd0);
    chk("stall c1 ens2", {31'd0, ens[2]}, 32'd0);
    step();
    chk("stall c2 ready", {31'd0, cfg_if.CFG_READY}, 32'd0);
    step();
    chk("stall c3 ready", {31'd0, cfg_if.CFG_READY}, 32'd1);
    chk("stall c3 ens2", {31'd0, ens[2]}, 32'd0);
    step();
    req(1'b0, 2'd0, 24'd0, 1'b0);
    chk("stall c4 ens2", {31'd0, ens[2]}, 32'd1);
    step();
    step();
    chk("ch2 t2 tick2", {31'd0, tick[2]}, 32'd0);
    step();
    chk("ch2 t3 tick2", {31'd0, tick[2]}, 32'd1);

    // Mid-run reset with a pending update queued
    req(1'b1, 2'd0, 24'd5, 1'b1);
    step();
    req(1'b0, 2'd0, 24'd0, 1'b0);
    rst_n = 1'b0;
    step();
    chk("rst tick", {28'd0, tick}, 32'd0);
    chk("rst slow", {28'd0, slow}, 32'd0);
    chk("rst ens", {28'd0, ens}, 32'd0);
    chk("rst ready", {31'd0, cfg_if.CFG_READY}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("post rst ready", {31'd0, cfg_if.CFG_READY}, 32'd1);
    chk("post rst ens", {28'd0, ens}, 32'd0);
    chk("post rst tick", {28'd0, tick}, 32'd0);

    // Out-of-range channel on a 3-channel instance is accepted and dropped
    cfg3_if.CFG_VALID = 1'b1;
    cfg3_if.CFG_CH    = 2'd3;
    cfg3_if.CFG_DIV   = 8'd0;
    cfg3_if.CFG_EN    = 1'b1;
    step();
    chk("oor ens", {29'd0, ens3}, 32'd0);
    chk("oor ready", {31'd0, cfg3_if.CFG_READY}, 32'd1);
    cfg3_if.CFG_CH = 2'd2;
    step();
    cfg3_if.CFG_VALID = 1'b0;
    chk("ch2of3 ens", {29'd0, ens3}, 32'h4);
    step();
    chk("ch2of3 tick", {29'd0, tick3}, 32'h4);

`ifdef SCHED_SYNC_EN
    // SYNC restarts ch0 (D=3) and ch1 (D=5); lands on ch0's wrap edge
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req(1'b1, 2'd0, 24'd3, 1'b1);
    step();
    req(1'b1, 2'd1, 24'd5, 1'b1);
    step();
    req(1'b0, 2'd0, 24'd0, 1'b0);
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync tick", {28'd0, tick}, 32'd0);
    chk("sync slow", {28'd0, slow}, 32'd0);
    chk("sync ens", {28'd0, ens}, 32'h3);
    for (int n = 1; n <= 3; n++) begin
      step();
      chk($sformatf("sync +%0d tick", n), {28'd0, tick}, 32'd0);
    end
    step();
    chk("sync +4 tick", {28'd0, tick}, 32'h1);
    chk("sync +4 slow", {28'd0, slow}, 32'h1);
    step();
    chk("sync +5 tick", {28'd0, tick}, 32'h0);
    step();
    chk("sync +6 tick", {28'd0, tick}, 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
